// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the unified-memory arbiter: FSM state encoding,
// requester port identifiers and the memory depth shared with the memory block.
// No ports.
// -----------------------------------------------------------------------------
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  localparam int MEM_DEPTH = 1024;

endpackage

// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
// Bundles the two requester handshakes (fetch port I, load/store port D), the
// memory-side strobes and the arbiter status signals.
//   master : requester/memory environment (drives req, addr, wdata, mem_rdata)
//   slave  : the arbiter (drives acks, rdata, err, mem_* strobes, busy, grant)
// Parameters: AW address width, DW data width.
// -----------------------------------------------------------------------------
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);

  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_ack;
  logic [DW-1:0] i_rdata;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ack;
  logic [DW-1:0] d_rdata;

  logic          err;

  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_write;
  logic          mem_read;
  logic [DW-1:0] mem_rdata;

  logic          busy;
  logic          grant;

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  i_ack, i_rdata, d_ack, d_rdata, err,
           mem_addr, mem_wdata, mem_write, mem_read, busy, grant
  );

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output i_ack, i_rdata, d_ack, d_rdata, err,
           mem_addr, mem_wdata, mem_write, mem_read, busy, grant
  );

endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-input round-robin picker. Holds the last-grant flip-flop; on a tie the
// port that did not win last time is picked.
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   i_reqI       request from port I
//   i_reqD       request from port D
//   i_update     commit the current pick as the new last grant
//   o_grant      combinational pick (0 = I, 1 = D)
//   o_valid      at least one request present
//   o_last       registered last grant (reset to D so I wins the first tie)
// -----------------------------------------------------------------------------
module rr_arb2
  import mem_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic i_reqI,
  input  logic i_reqD,
  input  logic i_update,
  output logic o_grant,
  output logic o_valid,
  output logic o_last
);

  logic r_last;

  // Tie goes to the port that was not granted last.
  always_comb begin
    o_grant = r_last;
    if (i_reqI && i_reqD) begin
      o_grant = ~r_last;
    end else if (i_reqI) begin
      o_grant = PORT_I;
    end else if (i_reqD) begin
      o_grant = PORT_D;
    end
  end

  assign o_valid = i_reqI | i_reqD;
  assign o_last  = r_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last <= PORT_D;
    end else if (i_update && o_valid) begin
      r_last <= o_grant;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Sequences the shared unified memory between instruction fetch (port I,
// read-only) and load/store (port D, read/write). Requests are arbitrated
// round-robin in IDLE, the chosen address/we/wdata are latched and held on the
// memory bus for MEM_LAT strobe cycles, then a one-cycle RESP returns the ack
// (and read data) to the owning port. Out-of-range addresses skip the memory
// and answer with err after one cycle.
// Parameters: MEM_LAT strobe cycles (>=1), DEPTH valid words, AW, DW widths.
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   bus          mem_arbiter_if slave modport (handshakes, mem_*, status)
// -----------------------------------------------------------------------------
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int MEM_LAT = 2,
  parameter int DEPTH   = MEM_DEPTH,
  parameter int AW      = 32,
  parameter int DW      = 32
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(MEM_LAT - 1);

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_port;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic          r_memRead;
  logic          r_memWrite;
  logic          r_iAck;
  logic          r_dAck;
  logic          r_err;
  logic [DW-1:0] r_iRdata;
  logic [DW-1:0] r_dRdata;

  logic          w_grant;
  logic          w_valid;
  logic          w_last;
  logic [AW-1:0] w_selAddr;
  logic          w_selWe;
  logic          w_addrOk;

  rr_arb2 u_arb (
    .clk      (clk),
    .reset    (reset),
    .i_reqI   (bus.i_req),
    .i_reqD   (bus.d_req),
    .i_update (r_state == IDLE),
    .o_grant  (w_grant),
    .o_valid  (w_valid),
    .o_last   (w_last)
  );

  // Port I is always a read, so only D's we can select a write.
  assign w_selAddr = (w_grant == PORT_D) ? bus.d_addr : bus.i_addr;
  assign w_selWe   = (w_grant == PORT_D) & bus.d_we;
  assign w_addrOk  = (w_selAddr < AW'(DEPTH));

  // Single FSM: grant/latch in IDLE, hold strobes in ACCESS, pulse ack in RESP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_port     <= PORT_I;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_memRead  <= 1'b0;
      r_memWrite <= 1'b0;
      r_iAck     <= 1'b0;
      r_dAck     <= 1'b0;
      r_err      <= 1'b0;
      r_iRdata   <= '0;
      r_dRdata   <= '0;
    end else begin
      r_iAck <= 1'b0;
      r_dAck <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_valid) begin
            r_port  <= w_grant;
            r_we    <= w_selWe;
            r_addr  <= w_selAddr;
            r_wdata <= bus.d_wdata;
            r_cnt   <= '0;
            if (w_addrOk) begin
              r_state    <= ACCESS;
              r_memRead  <= ~w_selWe;
              r_memWrite <= w_selWe;
            end else begin
              // Bad address: no memory cycle, reads return zero, writes dropped.
              r_state <= RESP;
              r_err   <= 1'b1;
              if (w_grant == PORT_I) begin
                r_iAck   <= 1'b1;
                r_iRdata <= '0;
              end else begin
                r_dAck <= 1'b1;
                if (!w_selWe) begin
                  r_dRdata <= '0;
                end
              end
            end
          end
        end
        ACCESS: begin
          if (r_cnt == LAST_CNT) begin
            r_state    <= RESP;
            r_memRead  <= 1'b0;
            r_memWrite <= 1'b0;
            if (r_port == PORT_I) begin
              r_iAck   <= 1'b1;
              r_iRdata <= bus.mem_rdata;
            end else begin
              r_dAck <= 1'b1;
              if (!r_we) begin
                r_dRdata <= bus.mem_rdata;
              end
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RESP: begin
          // Always pass through IDLE so a req still high from the ack cycle
          // is not taken as a new request.
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.mem_read  = r_memRead;
  assign bus.mem_write = r_memWrite;
  assign bus.i_ack     = r_iAck;
  assign bus.d_ack     = r_dAck;
  assign bus.err       = r_err;
  assign bus.i_rdata   = r_iRdata;
  assign bus.d_rdata   = r_dRdata;
  assign bus.busy      = (r_state != IDLE);
  assign bus.grant     = w_last;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Directed testbench for mem_arbiter with a 1024-word memory model preloaded
// with mem[i] = i and MEM_LAT = 2.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;
  import mem_pkg::*;

  localparam int MEM_LAT = 2;
  localparam int AW      = 32;
  localparam int DW      = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] mem [0:1023];

  mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_arbiter #(
    .MEM_LAT (MEM_LAT),
    .DEPTH   (1024),
    .AW      (AW),
    .DW      (DW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Memory model: combinational read, write on the clock edge while strobed;
  // reloaded with mem[i] = i whenever reset is high.
  assign bus.mem_rdata = (bus.mem_addr < 32'd1024) ? mem[bus.mem_addr[9:0]] : '0;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 1024; i++) begin
        mem[i] <= DW'(i);
      end
    end else if (bus.mem_write && (bus.mem_addr < 32'd1024)) begin
      mem[bus.mem_addr[9:0]] <= bus.mem_wdata;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset;
    reset      = 1'b1;
    bus.i_req  = 1'b0;
    bus.i_addr = '0;
    bus.d_req  = 1'b0;
    bus.d_we   = 1'b0;
    bus.d_addr = '0;
    bus.d_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Raises one port's request, watches the bus until that port's ack (bounded),
  // drops req and then spends one more cycle so the arbiter is back in IDLE.
  task automatic applyStimulus(
    input  logic        port,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  bit          changeAddr,
    input  logic [31:0] newAddr,
    output int          lat,
    output int          rdCnt,
    output int          wrCnt,
    output logic [31:0] rdata,
    output logic        errSeen,
    output logic        otherAck,
    output logic        addrStable,
    output logic        overlap
  );
    lat = -1; rdCnt = 0; wrCnt = 0; rdata = '0;
    errSeen = 1'b0; otherAck = 1'b0; addrStable = 1'b1; overlap = 1'b0;
    if (port == PORT_I) begin
      bus.i_req  = 1'b1;
      bus.i_addr = addr;
    end else begin
      bus.d_req   = 1'b1;
      bus.d_we    = we;
      bus.d_addr  = addr;
      bus.d_wdata = wdata;
    end
    for (int n = 1; n <= 10; n++) begin
      tick();
      if (n == 1 && changeAddr) begin
        if (port == PORT_I) bus.i_addr = newAddr;
        else                bus.d_addr = newAddr;
      end
      if (bus.mem_read)  rdCnt++;
      if (bus.mem_write) wrCnt++;
      if (bus.mem_read && bus.mem_write) overlap = 1'b1;
      if ((bus.mem_read || bus.mem_write) && (bus.mem_addr !== addr)) addrStable = 1'b0;
      if ((port == PORT_I) ? bus.d_ack : bus.i_ack) otherAck = 1'b1;
      if ((port == PORT_I) ? bus.i_ack : bus.d_ack) begin
        lat     = n;
        rdata   = (port == PORT_I) ? bus.i_rdata : bus.d_rdata;
        errSeen = bus.err;
        break;
      end
    end
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    tick();
  endtask

  int          lat, rdCnt, wrCnt, waitN;
  logic [31:0] rdata;
  logic        errSeen, otherAck, addrStable, overlap;

  initial begin
    $display("[TB] start");
    doReset();

    // Reset state
    checkOutput("rst_busy",  {31'd0, bus.busy},      32'd0);
    checkOutput("rst_grant", {31'd0, bus.grant},     32'd1);
    checkOutput("rst_read",  {31'd0, bus.mem_read},  32'd0);
    checkOutput("rst_write", {31'd0, bus.mem_write}, 32'd0);
    checkOutput("rst_iack",  {31'd0, bus.i_ack},     32'd0);
    checkOutput("rst_irdata", bus.i_rdata, 32'd0);
    checkOutput("rst_drdata", bus.d_rdata, 32'd0);

    // Fetch from address 5
    applyStimulus(PORT_I, 1'b0, 32'd5, 32'd0, 1'b0, 32'd0,
                  lat, rdCnt, wrCnt, rdata, errSeen, otherAck, addrStable, overlap);
    checkOutput("i5_lat",    lat,   32'd3);
    checkOutput("i5_rdcnt",  rdCnt, 32'd2);
    checkOutput("i5_wrcnt",  wrCnt, 32'd0);
    checkOutput("i5_rdata",  rdata, 32'd5);
    checkOutput("i5_addr",   {31'd0, addrStable}, 32'd1);
    checkOutput("i5_dack",   {31'd0, otherAck},   32'd0);
    checkOutput("i5_err",    {31'd0, errSeen},    32'd0);
    checkOutput("i5_idle",   {31'd0, bus.busy},   32'd0);
    checkOutput("i5_grant",  {31'd0, bus.grant},  32'd0);

    // Write 0xDEADBEEF to 10, then read it back
    applyStimulus(PORT_D, 1'b1, 32'd10, 32'hDEADBEEF, 1'b0, 32'd0,
                  lat, rdCnt, wrCnt, rdata, errSeen, otherAck, addrStable, overlap);
    checkOutput("w10_lat",   lat,   32'd3);
    checkOutput("w10_wrcnt", wrCnt, 32'd2);
    checkOutput("w10_rdcnt", rdCnt, 32'd0);
    checkOutput("w10_ovl",   {31'd0, overlap},    32'd0);
    checkOutput("w10_addr",  {31'd0, addrStable}, 32'd1);
    checkOutput("w10_grant", {31'd0, bus.grant},  32'd1);
    applyStimulus(PORT_D, 1'b0, 32'd10, 32'd0, 1'b0, 32'd0,
                  lat, rdCnt, wrCnt, rdata, errSeen, otherAck, addrStable, overlap);
    checkOutput("r10_lat",   lat,   32'd3);
    checkOutput("r10_rdata", rdata, 32'hDEADBEEF);
    checkOutput("r10_rdcnt", rdCnt, 32'd2);
    checkOutput("r10_iack",  {31'd0, otherAck}, 32'd0);
    checkOutput("r10_irdata", bus.i_rdata, 32'd5);

    // Simultaneous requests held high: I, D, I, D with an idle cycle after each ack
    doReset();
    bus.i_req  = 1'b1;
    bus.i_addr = 32'd2;
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 32'd6;
    for (int k = 0; k < 4; k++) begin
      waitN = 0;
      while (!(bus.i_ack || bus.d_ack) && waitN < 8) begin
        tick();
        waitN++;
      end
      checkOutput($sformatf("rr%0d_wait", k), waitN, 32'd3);
      checkOutput($sformatf("rr%0d_dack", k), {31'd0, bus.d_ack}, (k % 2 == 1) ? 32'd1 : 32'd0);
      checkOutput($sformatf("rr%0d_iack", k), {31'd0, bus.i_ack}, (k % 2 == 0) ? 32'd1 : 32'd0);
      checkOutput($sformatf("rr%0d_irdata", k), bus.i_rdata, 32'd2);
      checkOutput($sformatf("rr%0d_drdata", k), bus.d_rdata, (k == 0) ? 32'd0 : 32'd6);
      if (k == 3) begin
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
      end
      tick();
      checkOutput($sformatf("rr%0d_idle", k), {31'd0, bus.busy}, 32'd0);
    end
    tick();
    checkOutput("rr_quiet", {31'd0, bus.busy}, 32'd0);

    // Out-of-range read, then a normal read
    applyStimulus(PORT_D, 1'b0, 32'd1024, 32'd0, 1'b0, 32'd0,
                  lat, rdCnt, wrCnt, rdata, errSeen, otherAck, addrStable, overlap);
    checkOutput("bad_lat",   lat,   32'd1);
    checkOutput("bad_rdcnt", rdCnt, 32'd0);
    checkOutput("bad_wrcnt", wrCnt, 32'd0);
    checkOutput("bad_err",   {31'd0, errSeen}, 32'd1);
    checkOutput("bad_rdata", rdata, 32'd0);
    applyStimulus(PORT_D, 1'b0, 32'd3, 32'd0, 1'b0, 32'd0,
                  lat, rdCnt, wrCnt, rdata, errSeen, otherAck, addrStable, overlap);
    checkOutput("r3_lat",   lat,   32'd3);
    checkOutput("r3_rdata", rdata, 32'd3);
    checkOutput("r3_err",   {31'd0, errSeen}, 32'd0);

    // Reset during the second ACCESS cycle of a write to 20
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 32'd20;
    bus.d_wdata = 32'h55;
    tick();
    checkOutput("mid_wr1", {31'd0, bus.mem_write}, 32'd1);
    tick();
    checkOutput("mid_wr2", {31'd0, bus.mem_write}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("mid_write", {31'd0, bus.mem_write}, 32'd0);
    checkOutput("mid_read",  {31'd0, bus.mem_read},  32'd0);
    checkOutput("mid_busy",  {31'd0, bus.busy},      32'd0);
    checkOutput("mid_dack",  {31'd0, bus.d_ack},     32'd0);
    bus.d_req = 1'b0;
    bus.d_we  = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("mid_idle", {31'd0, bus.busy}, 32'd0);
    applyStimulus(PORT_I, 1'b0, 32'd7, 32'd0, 1'b0, 32'd0,
                  lat, rdCnt, wrCnt, rdata, errSeen, otherAck, addrStable, overlap);
    checkOutput("i7_lat",   lat,   32'd3);
    checkOutput("i7_rdata", rdata, 32'd7);
    checkOutput("i7_dack",  {31'd0, otherAck}, 32'd0);

    // Address change during ACCESS is ignored
    applyStimulus(PORT_I, 1'b0, 32'd4, 32'd0, 1'b1, 32'd9,
                  lat, rdCnt, wrCnt, rdata, errSeen, otherAck, addrStable, overlap);
    checkOutput("i4_lat",   lat,   32'd3);
    checkOutput("i4_addr",  {31'd0, addrStable}, 32'd1);
    checkOutput("i4_rdata", rdata, 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences the shared 1024-word unified memory between two requesters: instruction fetch (port I, read-only) and load/store (port D, read/write).
- Sits between the multi-cycle control unit/datapath and the memory block.
- Drives the memory's addr / data_in / write_signal / read_signal and captures data_out after a fixed access latency.
- Uses a req/ack handshake toward each requester and round-robin arbitration when both request at once.

Parameters:
- MEM_LAT, 2: cycles the memory strobe is held per access (≥1).
- DEPTH, 1024: number of valid word addresses; addresses ≥ DEPTH are errors.
- AW, 32: address width.
- DW, 32: data width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- i_req  in  1  fetch request; held high until i_ack.
- i_addr  in  AW  fetch word address; stable while i_req is high.
- i_ack  out  1  one-cycle completion pulse for port I.
- i_rdata  out  DW  fetched word; valid with i_ack, held until the next i_ack.
- d_req  in  1  data request; held high until d_ack.
- d_we  in  1  1 = write, 0 = read; stable while d_req is high.
- d_addr  in  AW  data word address.
- d_wdata  in  DW  write data.
- d_ack  out  1  one-cycle completion pulse for port D.
- d_rdata  out  DW  load data; valid with d_ack, held until the next d_ack.
- err  out  1  pulses with the ack when the address was ≥ DEPTH.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_write  out  1  memory write strobe.
- mem_read  out  1  memory read strobe.
- mem_rdata  in  DW  memory read data.
- busy  out  1  high whenever state ≠ IDLE.
- grant  out  1  owner of the current or last access: 0 = I, 1 = D.

Behaviour:
- States:
  - IDLE → ACCESS on any request with a valid address.
  - IDLE → RESP directly on a request with an invalid address.
  - ACCESS → RESP when the strobe counter reaches MEM_LAT−1.
  - RESP → IDLE unconditionally.
- Reset, asynchronous: all outputs 0, mem_* 0, state IDLE, counter 0, grant = 1 (so port I wins the first tie), rdata registers 0.
- Reset mid-ACCESS drops the strobes immediately; the partial access is discarded and no ack is issued.
- Arbitration, evaluated only in IDLE on a clock edge:
  - Only one req high: grant that port.
  - Both high: grant the port ≠ last grant.
  - On grant, latch addr, we and wdata into internal registers. mem_* are driven only from these latched values; later requester changes are ignored.
- ACCESS:
  - mem_read = ~we or mem_write = we, held exactly MEM_LAT cycles.
  - Port I is always a read.
  - On a read, mem_rdata is captured at the edge ending the last strobe cycle.
  - mem_addr and mem_wdata are held constant for the whole state.
- RESP:
  - Exactly one cycle; the granted port's ack = 1.
  - Read data appears on that port's rdata in the same cycle.
  - The other port's rdata is unchanged.
  - Strobes are 0.
- Invalid address (≥ DEPTH):
  - No strobe is asserted; RESP is entered the cycle after grant with err = 1.
  - Read data = 0; a write is dropped.
- Latency:
  - Valid access: ack occurs MEM_LAT+1 cycles after the IDLE edge that sampled req.
  - Invalid access: ack after 1 cycle.
- Handshake and turnaround:
  - A requester drops req at the edge following its ack.
  - The arbiter spends one IDLE cycle after RESP, so a still-high req in that cycle is not mistaken for a new request.
  - Minimum spacing between accesses is MEM_LAT+2 cycles.
- A req that rises during ACCESS/RESP waits; no request is lost or duplicated.
- Starvation bound: each port waits at most one foreign access.
- Strobes are never both high; mem_write and mem_read are mutually exclusive by construction.

Decomposition:
- Shared package mem_pkg:
  - State encoding: IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2.
  - Port IDs: PORT_I = 0, PORT_D = 1.
  - MEM_DEPTH = 1024, shared with the memory block.
- One natural sub-module, rr_arb2: 2-input round-robin picker holding the last-grant flip-flop, outputs grant + valid.
- FSM, latency counter and data capture stay in mem_arbiter.

Test Plan:
- Memory preloaded mem[i] = i; i_req with i_addr = 5, MEM_LAT = 2:
  - mem_read high exactly 2 cycles with mem_addr = 5.
  - i_ack pulses 3 cycles after the sample edge, i_rdata = 5.
  - d_ack stays 0.
- d_req, d_we = 1, d_addr = 10, d_wdata = 0xDEADBEEF, then a d read of address 10:
  - mem_write is high exactly 2 cycles and mem_read stays 0 during it.
  - The second access returns d_rdata = 0xDEADBEEF.
- i_req and d_req raised in the same cycle after reset, both held continuously:
  - Grants alternate I, D, I, D.
  - Each ack is followed by one idle cycle.
  - i_rdata is unchanged across D accesses.
- d_req read at d_addr = 1024:
  - No strobe asserted; d_ack and err pulse 1 cycle later; d_rdata = 0.
  - A following d read of address 3 returns 3 with err = 0.
- reset asserted in the 2nd ACCESS cycle of a write to address 20 (data 0x55):
  - Strobes, busy and acks drop asynchronously.
  - After release, the arbiter is IDLE and a new i_req at address 7 completes normally with i_rdata = 7.
- i_addr changed to 9 while the i_req for address 4 is in ACCESS:
  - mem_addr stays 4 and i_rdata = 4.
